// File: rtl/lzy_seq_pkg.sv
// Shared definitions for the "100"-sync serial frame transmitter family:
// state encoding, sync pattern and a helper that picks the sync bit by index.
package lzy_seq_pkg;

  localparam int SYNC_W = 3;
  localparam logic [SYNC_W-1:0] SYNC_PAT = 3'b100;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SYNC = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_PAR  = 3'd3;
  localparam logic [2:0] ST_GAP  = 3'd4;

  // Bit index width: wide enough for the largest payload (16 bits)
  localparam int IDX_W = 5;

  // Sync bits go out MSB of SYNC_PAT first
  function automatic logic sync_bit(input logic [IDX_W-1:0] idx);
    case (idx)
      5'd0:    sync_bit = SYNC_PAT[2];
      5'd1:    sync_bit = SYNC_PAT[1];
      default: sync_bit = SYNC_PAT[0];
    endcase
  endfunction

endpackage

// File: rtl/lzy_bit_tick.sv
// Bit-period timer: a BIT_DIV down-counter with synchronous clear.
// Tick marks the last cycle of a bit period; Tick_nxt tells whether the
// counter will be at its terminal value in the following cycle, which lets
// callers register outputs that line up with the tick.
module lzy_bit_tick #(
  parameter int BIT_DIV = 1
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Clr,
  input  logic En,
  output logic Tick,
  output logic Tick_nxt
);

  localparam int CNT_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(BIT_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // Reload on clear, otherwise count down and wrap while enabled
  always_comb begin
    cnt_nxt = cnt;
    if (Clr) begin
      cnt_nxt = LOAD;
    end else if (En) begin
      cnt_nxt = (cnt == '0) ? LOAD : cnt - CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

  assign Tick     = En && (cnt == '0);
  assign Tick_nxt = (cnt_nxt == '0);

endmodule

// File: rtl/lzy_seq_tx.sv
// Serial frame transmitter: accepts a word on a valid/ready handshake and
// emits sync 1,0,0, the payload MSB-first and GAP_BITS idle zeros, each bit
// held BIT_DIV cycles. All outputs are flops loaded from the next-state
// values, so what appears on the pins always matches the current state.
// Optional build macro: LZY_SEQ_TX_PARITY_EN adds an even-parity bit after
// the payload.
module lzy_seq_tx
  import lzy_seq_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int BIT_DIV  = 1,
  parameter int GAP_BITS = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] D_in,
  input  logic              D_valid,
  output logic              D_ready,
  output logic              S_out,
  output logic              S_act,
  output logic              D_done
);

  logic [2:0]        state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [DATA_W-1:0] sreg, sreg_nxt;
  logic              accept;
  logic              tick, tick_nxt;
  logic              s_out_nxt;
  logic              done_nxt;
`ifdef LZY_SEQ_TX_PARITY_EN
  logic              par_r;
`endif

  assign accept = D_valid && D_ready;

  lzy_bit_tick #(
    .BIT_DIV (BIT_DIV)
  ) u_tick (
    .Clk      (Clk),
    .Reset    (Reset),
    .Clr      (accept),
    .En       (state != ST_IDLE),
    .Tick     (tick),
    .Tick_nxt (tick_nxt)
  );

  // State, bit index and shift register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= ST_IDLE;
      idx   <= '0;
      sreg  <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      sreg  <= sreg_nxt;
    end
  end

`ifdef LZY_SEQ_TX_PARITY_EN
  // Parity is taken from the word as captured, before it is shifted out
  always_ff @(posedge Clk) begin
    if (Reset) begin
      par_r <= 1'b0;
    end else if (accept) begin
      par_r <= ^D_in;
    end
  end
`endif

  // Next-state: advance the bit index on each bit-period tick
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    sreg_nxt  = sreg;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = ST_SYNC;
          idx_nxt   = '0;
          sreg_nxt  = D_in;
        end
      end
      ST_SYNC: begin
        if (tick) begin
          if (idx == IDX_W'(SYNC_W - 1)) begin
            state_nxt = ST_DATA;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          sreg_nxt = {sreg[DATA_W-2:0], 1'b0};
          if (idx == IDX_W'(DATA_W - 1)) begin
`ifdef LZY_SEQ_TX_PARITY_EN
            state_nxt = ST_PAR;
`else
            state_nxt = ST_GAP;
`endif
            idx_nxt = '0;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end
      ST_PAR: begin
        if (tick) begin
          state_nxt = ST_GAP;
          idx_nxt   = '0;
        end
      end
      ST_GAP: begin
        if (tick) begin
          if (idx == IDX_W'(GAP_BITS - 1)) begin
            state_nxt = ST_IDLE;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  // Output decode of the state the block will be in next cycle
  always_comb begin
    s_out_nxt = 1'b0;
    case (state_nxt)
      ST_SYNC: s_out_nxt = sync_bit(idx_nxt);
      ST_DATA: s_out_nxt = sreg_nxt[DATA_W-1];
`ifdef LZY_SEQ_TX_PARITY_EN
      ST_PAR:  s_out_nxt = par_r;
`endif
      default: s_out_nxt = 1'b0;
    endcase
    done_nxt = (state_nxt == ST_GAP) && (idx_nxt == IDX_W'(GAP_BITS - 1)) && tick_nxt;
  end

  // Output registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      S_out   <= 1'b0;
      S_act   <= 1'b0;
      D_done  <= 1'b0;
      D_ready <= 1'b1;
    end else begin
      S_out   <= s_out_nxt;
      S_act   <= (state_nxt != ST_IDLE);
      D_done  <= done_nxt;
      D_ready <= (state_nxt == ST_IDLE);
    end
  end

endmodule

// File: tb/tb_lzy_seq_tx.sv
// Self-checking bench for lzy_seq_tx: two instances (BIT_DIV=1 and 4),
// expected bit streams built from the frame rules in a small model.
module tb_lzy_seq_tx;

  localparam int DW = 8;
  localparam int GB = 2;
`ifdef LZY_SEQ_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst1, v1, rdy1, so1, act1, done1;
  logic [DW-1:0] din1;
  logic          rst4, v4, rdy4, so4, act4, done4;
  logic [DW-1:0] din4;

  lzy_seq_tx #(.DATA_W(DW), .BIT_DIV(1), .GAP_BITS(GB)) dut1 (
    .Clk(clk), .Reset(rst1), .D_in(din1), .D_valid(v1),
    .D_ready(rdy1), .S_out(so1), .S_act(act1), .D_done(done1)
  );

  lzy_seq_tx #(.DATA_W(DW), .BIT_DIV(4), .GAP_BITS(GB)) dut4 (
    .Clk(clk), .Reset(rst4), .D_in(din4), .D_valid(v4),
    .D_ready(rdy4), .S_out(so4), .S_act(act4), .D_done(done4)
  );

  int   vectors = 0;
  int   miscompares = 0;
  logic exp_q[$];
  logic stream[$];
  int   cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc > 60000) begin
      $display("FAIL watchdog: cycle %0d exceeded budget 60000", cyc);
      $fatal(1);
    end
  end

  // Expected S_out per cycle for one frame
  function automatic void build_expect(input logic [DW-1:0] w, input int div);
    logic bits[$];
    exp_q.delete();
    bits.push_back(1'b1);
    bits.push_back(1'b0);
    bits.push_back(1'b0);
    for (int i = DW - 1; i >= 0; i--) bits.push_back(w[i]);
    if (PB == 1) bits.push_back(^w);
    for (int i = 0; i < GB; i++) bits.push_back(1'b0);
    foreach (bits[i]) for (int j = 0; j < div; j++) exp_q.push_back(bits[i]);
  endfunction

  function automatic logic [3:0] obs(input int sel);
    if (sel == 0) return {so1, act1, rdy1, done1};
    return {so4, act4, rdy4, done4};
  endfunction

  task automatic set_valid(input int sel, input logic v, input logic [DW-1:0] w);
    if (sel == 0) begin v1 = v; din1 = w; end
    else begin v4 = v; din4 = w; end
  endtask

  // Wait (bounded) for ready, present the word for exactly one edge
  task automatic start_word(input int sel, input logic [DW-1:0] w, input string name);
    logic [3:0] o;
    int n;
    n = 0;
    o = obs(sel);
    while (o[1] !== 1'b1 && n < 500) begin
      @(posedge clk); #1;
      o = obs(sel);
      n++;
    end
    vectors++;
    if (o[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_ready_wait: D_ready=%b after %0d cycles, required 1", name, o[1], n);
    end
    set_valid(sel, 1'b1, w);
    @(posedge clk); #1;
    set_valid(sel, 1'b0, w);
  endtask

  // Called in the first cycle of a frame; ends in the cycle after it
  task automatic check_frame(input int sel, input logic [DW-1:0] w, input int div,
                             input string name);
    logic [3:0] o, e;
    int len;
    build_expect(w, div);
    len = exp_q.size();
    for (int k = 0; k < len; k++) begin
      o = obs(sel);
      e = {exp_q[k], 1'b1, 1'b0, (k == len - 1)};
      stream.push_back(o[3]);
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL %s cycle %0d: {S_out,S_act,D_ready,D_done}=%b required %b",
                 name, k + 1, o, e);
      end
      @(posedge clk); #1;
    end
    o = obs(sel);
    stream.push_back(o[3]);
    vectors++;
    if (o !== 4'b0010) begin
      miscompares++;
      $display("FAIL %s_end: {S_out,S_act,D_ready,D_done}=%b required 0010", name, o);
    end
  endtask

  task automatic test_reset();
    logic [3:0] o1, o4;
    rst1 = 1'b1; rst4 = 1'b1;
    v1 = 1'b0; v4 = 1'b0; din1 = '0; din4 = '0;
    repeat (3) @(posedge clk);
    #1;
    o1 = obs(0); o4 = obs(1);
    vectors += 2;
    if (o1 !== 4'b0010) begin
      miscompares++;
      $display("FAIL reset_div1: outputs=%b required 0010", o1);
    end
    if (o4 !== 4'b0010) begin
      miscompares++;
      $display("FAIL reset_div4: outputs=%b required 0010", o4);
    end
    rst1 = 1'b0; rst4 = 1'b0;
    @(posedge clk); #1;
    o1 = obs(0);
    vectors++;
    if (o1 !== 4'b0010) begin
      miscompares++;
      $display("FAIL reset_release: outputs=%b required 0010", o1);
    end
  endtask

  task automatic test_basic();
    start_word(0, 8'hA5, "a5");
    check_frame(0, 8'hA5, 1, "a5");
    start_word(0, 8'h07, "w07");
    check_frame(0, 8'h07, 1, "w07");
  endtask

  task automatic test_random();
    logic [DW-1:0] w;
    for (int i = 0; i < 6; i++) begin
      w = DW'($urandom);
      start_word(0, w, "rand1");
      check_frame(0, w, 1, "rand1");
    end
  endtask

  task automatic test_bit_div();
    logic [DW-1:0] w;
    start_word(1, 8'h01, "div4_01");
    check_frame(1, 8'h01, 4, "div4_01");
    w = DW'($urandom);
    start_word(1, w, "div4_rand");
    check_frame(1, w, 4, "div4_rand");
  endtask

  task automatic test_back_to_back();
    v1 = 1'b1; din1 = 8'h00;
    @(posedge clk); #1;
    din1 = 8'hFF;
    check_frame(0, 8'h00, 1, "b2b_first");
    @(posedge clk); #1;
    v1 = 1'b0;
    check_frame(0, 8'hFF, 1, "b2b_second");
  endtask

  task automatic test_reset_mid_frame();
    logic [DW-1:0] w;
    logic [3:0] o, e;
    int done_seen;
    w = DW'($urandom);
    start_word(0, w, "midrst");
    repeat (6) begin @(posedge clk); #1; end
    o = obs(0);
    e = {w[DW-4], 1'b1, 1'b0, 1'b0};
    vectors++;
    if (o !== e) begin
      miscompares++;
      $display("FAIL midrst_bit3: outputs=%b required %b", o, e);
    end
    rst1 = 1'b1;
    @(posedge clk); #1;
    rst1 = 1'b0;
    o = obs(0);
    vectors++;
    if (o !== 4'b0010) begin
      miscompares++;
      $display("FAIL midrst_after: outputs=%b required 0010", o);
    end
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      o = obs(0);
      if (o[0] === 1'b1 || o[2] === 1'b1) done_seen++;
    end
    vectors++;
    if (done_seen != 0) begin
      miscompares++;
      $display("FAIL midrst_quiet: %0d cycles with D_done/S_act high, required 0", done_seen);
    end
    w = DW'($urandom);
    start_word(0, w, "midrst_next");
    check_frame(0, w, 1, "midrst_next");
  endtask

  // Count "100" windows in the serial stream over three all-zero frames
  task automatic test_detector();
    int hits, badpos, stride;
    stream.delete();
    for (int f = 0; f < 3; f++) begin
      start_word(0, 8'h00, "det");
      check_frame(0, 8'h00, 1, "det");
    end
    stride = 3 + DW + PB + GB + 1;
    hits = 0;
    badpos = 0;
    for (int i = 0; i + 2 < stream.size(); i++) begin
      if (stream[i] === 1'b1 && stream[i+1] === 1'b0 && stream[i+2] === 1'b0) begin
        hits++;
        if (i % stride != 0) badpos++;
      end
    end
    vectors += 2;
    if (hits != 3) begin
      miscompares++;
      $display("FAIL det_count: %0d sync detections, required 3", hits);
    end
    if (badpos != 0) begin
      miscompares++;
      $display("FAIL det_position: %0d detections off frame start, required 0", badpos);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_bit_div();
    test_back_to_back();
    test_reset_mid_frame();
    test_detector();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lzy_seq_tx.md
Name: lzy_seq_tx

Overview:
Serial frame transmitter that drives a single-wire bit stream for the "100" sequence-detector FSM. It accepts a parallel word through a valid/ready handshake. It then emits the sync pattern 1,0,0, the data word MSB-first, and a run of idle zeros. The downstream detector sees "100" and re-synchronises before every word. It sits between a parallel producer (counter, register bank) and the serial detector/receiver path.

Parameters:
DATA_W, 8, payload width in bits (2..16)
BIT_DIV, 1, clock cycles each serial bit is held (1..255)
GAP_BITS, 2, idle zero bits appended after payload (1..7)

Ports:
Clk  in  1  system clock, all logic on posedge
Reset  in  1  synchronous, active-high reset
D_in  in  DATA_W  parallel word to transmit
D_valid  in  1  producer has a word on D_in
D_ready  out  1  block can accept a word (high only in IDLE)
S_out  out  1  serial output bit stream
S_act  out  1  high while a frame (sync+data+gap) is on S_out
D_done  out  1  one-cycle pulse on the final cycle of a frame

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high: it is sampled only on the Clk posedge.
- Reset values: state=IDLE, S_out=0, S_act=0, D_done=0, D_ready=1, shift register=0, counters=0.
- Handshake: a word is accepted on a posedge with D_valid&&D_ready. D_in is captured into the shift register on that edge. D_ready falls in the following cycle. D_in is don't-care after acceptance. D_valid without D_ready is ignored; the producer holds it.
- States: IDLE, SYNC, DATA, GAP. All outputs are registered.
  - IDLE: S_out=0, S_act=0. On accept go to SYNC with bit index 0.
  - SYNC: emits 1,0,0 (index 0..2), each bit held BIT_DIV cycles. After the third bit, go to DATA.
  - DATA: emits shift-reg MSB, then shifts left. After DATA_W bits, go to GAP (or PARITY, see below).
  - GAP: S_out=0 for GAP_BITS*BIT_DIV cycles. D_done=1 on the last GAP cycle. Then go to IDLE.
- Latency: the first sync bit appears on S_out the cycle after acceptance.
- Frame length: (3+DATA_W+GAP_BITS)*BIT_DIV cycles, measured from the first sync bit to the last GAP cycle inclusive.
- Throughput: D_ready is high the cycle after D_done. Back-to-back words therefore cost one IDLE cycle between frames.
- Bit-timing counter: counts 0..BIT_DIV-1. The bit index advances when it wraps. BIT_DIV=1 advances every cycle.
- Reset mid-frame: the frame is abandoned on that edge. All outputs return to reset values the next cycle and no D_done is issued.
- Payload may itself contain 1,0,0. Emulation of the sync pattern inside the payload is the receiver's concern; the transmitter does no escaping.
- S_act=1 from the first sync bit through the last GAP cycle inclusive.

Optional Feature:
- Macro: LZY_SEQ_TX_PARITY_EN.
- Defined: a PARITY state follows DATA and emits one even-parity bit (XOR of the captured word) for BIT_DIV cycles. Frame length becomes (4+DATA_W+GAP_BITS)*BIT_DIV.
- Undefined: no PARITY state; DATA goes directly to GAP.

Decomposition:
- Shared package lzy_seq_pkg:
  - state encoding constants ST_IDLE, ST_SYNC, ST_DATA, ST_PAR, ST_GAP (3-bit)
  - SYNC_PAT=3'b100
  - SYNC_W=3
- Sub-module lzy_bit_tick: BIT_DIV down-counter with synchronous clear. Outputs a one-cycle tick at bit end. It is reused by future serial blocks.

Test Plan:
- DATA_W=8, BIT_DIV=1, GAP_BITS=2, D_in=8'hA5 accepted: S_out = 1,0,0,1,0,1,0,0,1,0,1,0,0. S_act high for 13 cycles. D_done on cycle 13. D_ready high on cycle 14.
- BIT_DIV=4, D_in=8'h01: each bit held 4 cycles. S_out is 1 for cycles 1-4 and for payload-LSB cycles 41-44. Frame is 52 cycles.
- D_valid held high with D_in 8'h00 then 8'hFF: the second accept occurs exactly one IDLE cycle after the first D_done. The second payload is eight 1s.
- Reset asserted in the DATA state at payload bit 3: the next cycle shows S_out=0, S_act=0, D_ready=1 and no D_done pulse. A new word is accepted normally afterwards.
- S_out fed into the "100" detector (active-low reset tied high), D_in=8'h00: the detector output asserts exactly once, one cycle after the third sync bit, per frame.
- With LZY_SEQ_TX_PARITY_EN defined, D_in=8'h07: a parity bit of 1 follows the payload. The frame is 14 cycles at BIT_DIV=1.
